// File: rtl/nios_jtag_debug_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module   : nios_jtag_debug_cmd_queue
// Brief    : System-clock-side receiver for the Nios II JTAG debug path.
//            Synchronises the TCK-domain update-IR / update-DR strobes,
//            captures IR and the scanned data register, buffers DR commands
//            in a show-ahead FIFO and presents the head as a one-hot action.
// Revision : 1.0 - initial release
// ============================================================================
module nios_jtag_debug_cmd_queue #(
  parameter int IR_W        = 2,
  parameter int DATA_W      = 38,
  parameter int SYNC_STAGES = 2,
  parameter int CMD_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        vs_uir,
  input  logic                        vs_udr,
  input  logic [IR_W-1:0]             ir_in,
  input  logic [DATA_W-1:0]           sr,
  input  logic                        cmd_ready,
  input  logic                        flush,
  input  logic                        ovf_clr,
  output logic [IR_W-1:0]             cur_ir,
  output logic                        ir_update,
  output logic                        cmd_valid,
  output logic [IR_W-1:0]             cmd_ir,
  output logic [DATA_W-1:0]           jdo,
  output logic [(2**IR_W)-1:0]        take_action,
  output logic [$clog2(CMD_DEPTH):0]  fill_level,
  output logic                        overflow
);

  localparam int c_AW = $clog2(CMD_DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam int c_EW = IR_W + DATA_W;

  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic                   r_uir_dly;
  logic                   r_udr_dly;
  logic                   w_uir_evt;
  logic                   w_udr_evt;

  logic [IR_W-1:0]        r_cur_ir;
  logic                   r_ir_update;

  logic [c_EW-1:0]        r_mem [CMD_DEPTH];
  logic [c_AW-1:0]        r_wr_ptr;
  logic [c_AW-1:0]        r_rd_ptr;
  logic [c_CW-1:0]        r_count;
  logic                   r_overflow;

  logic                   w_valid;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [c_EW-1:0]        w_head;

  // Strobe synchronisers plus one delayed copy for rising-edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uir_sync <= '0;
      r_udr_sync <= '0;
      r_uir_dly  <= 1'b0;
      r_udr_dly  <= 1'b0;
    end else begin
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
      r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
    end
  end

  assign w_uir_evt = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;
  assign w_udr_evt = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;

  // IR capture with a single-cycle update pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_ir    <= '0;
      r_ir_update <= 1'b0;
    end else begin
      r_ir_update <= w_uir_evt;
      if (w_uir_evt) begin
        r_cur_ir <= ir_in;
      end
    end
  end

  // A push into a full FIFO is still accepted when the head leaves that cycle;
  // flush discards any concurrent push without counting it as a drop.
  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == c_CW'(CMD_DEPTH));
  assign w_pop   = w_valid & cmd_ready;
  assign w_push  = w_udr_evt & ~flush & (~w_full | w_pop);
  assign w_drop  = w_udr_evt & ~flush & w_full & ~w_pop;

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_AW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + c_CW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - c_CW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  // Command storage; ir_in is taken directly so a same-cycle IR change is kept
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {ir_in, sr};
    end
  end

  // Head fields are forced to zero while empty so reset shows all-zero outputs
  assign w_head = r_mem[r_rd_ptr];
  assign cmd_ir = w_valid ? w_head[c_EW-1:DATA_W] : '0;
  assign jdo    = w_valid ? w_head[DATA_W-1:0]    : '0;

  // One-hot action decode of the head command
  always_comb begin
    take_action = '0;
    if (w_valid) begin
      take_action[cmd_ir] = 1'b1;
    end
  end

  assign cur_ir     = r_cur_ir;
  assign ir_update  = r_ir_update;
  assign cmd_valid  = w_valid;
  assign fill_level = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire
